// File: rtl/sumdiff_decode_pipe.sv
// Inverse add/sub butterfly: recovers A=(S+D)/2, B=(S-D)/2 from fixed-point sum/difference.
// Three-stage valid/ready pipeline: align, butterfly, rescale+clip.
module sumdiff_rescale #(
  parameter int IW = 20,
  parameter int IE = -12,
  parameter int OW = 16,
  parameter int OE = -8
) (
  input  logic signed [IW-1:0] x,
  output logic signed [OW-1:0] y,
  output logic                 sat
);
  localparam int RSH = (OE > IE) ? OE - IE : 0;
  localparam int LSH = (OE < IE) ? IE - OE : 0;
  localparam int XW  = IW + LSH;

  logic signed [XW-1:0] xs;
  // >>> on a signed operand floors toward -inf, which is the required rounding
  assign xs = (XW'(x) <<< LSH) >>> RSH;

  generate
    if (XW > OW) begin : g_clip
      localparam logic signed [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
      localparam logic signed [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};
      always_comb begin
        sat = 1'b0;
        y   = xs[OW-1:0];
        if (xs > XW'(OMAX)) begin
          y   = OMAX;
          sat = 1'b1;
        end else if (xs < XW'(OMIN)) begin
          y   = OMIN;
          sat = 1'b1;
        end
      end
    end else begin : g_pass
      assign y   = OW'(xs);
      assign sat = 1'b0;
    end
  endgenerate
endmodule

module sumdiff_decode_pipe #(
  parameter int S_W = 18,
  parameter int S_E = -10,
  parameter int D_W = 19,
  parameter int D_E = -11,
  parameter int A_W = 16,
  parameter int A_E = -8,
  parameter int B_W = 17,
  parameter int B_E = -9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [S_W-1:0] s_sig,
  input  logic signed [D_W-1:0] d_sig,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [A_W-1:0] a_sig,
  output logic signed [B_W-1:0] b_sig,
  output logic                  sat_a,
  output logic                  sat_b,
  output logic                  sat_seen
);
  localparam int STAGES = 3;
  localparam int E_M    = (S_E < D_E) ? S_E : D_E;
  localparam int S_SH   = S_E - E_M;
  localparam int D_SH   = D_E - E_M;
  localparam int S_AW   = S_W + S_SH;
  localparam int D_AW   = D_W + D_SH;
  // one guard bit so s1+d1 and s1-d1 never wrap
  localparam int W      = ((S_AW > D_AW) ? S_AW : D_AW) + 1;
  localparam int E_I    = E_M - 1;

  logic [STAGES:1] vld_pipe, rdy;
  logic signed [W-1:0] s_ext, d_ext, s1, d1, p2, m2;
  logic signed [A_W-1:0] a_nx;
  logic signed [B_W-1:0] b_nx;
  logic sa_nx, sb_nx;

  assign rdy[3]    = !vld_pipe[3] || out_ready;
  assign rdy[2]    = !vld_pipe[2] || rdy[3];
  assign rdy[1]    = !vld_pipe[1] || rdy[2];
  assign in_ready  = rdy[1];
  assign out_valid = vld_pipe[3];

  assign s_ext = W'(s_sig) <<< S_SH;
  assign d_ext = W'(d_sig) <<< D_SH;

  // p,m carry exponent E_I = E_M-1, so the /2 costs nothing
  sumdiff_rescale #(.IW(W), .IE(E_I), .OW(A_W), .OE(A_E)) u_resc_a (
    .x(p2), .y(a_nx), .sat(sa_nx)
  );
  sumdiff_rescale #(.IW(W), .IE(E_I), .OW(B_W), .OE(B_E)) u_resc_b (
    .x(m2), .y(b_nx), .sat(sb_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      d1       <= '0;
      p2       <= '0;
      m2       <= '0;
      a_sig    <= '0;
      b_sig    <= '0;
      sat_a    <= 1'b0;
      sat_b    <= 1'b0;
      sat_seen <= 1'b0;
    end else begin
      if (rdy[1]) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          s1 <= s_ext;
          d1 <= d_ext;
        end
      end
      if (rdy[2]) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          p2 <= s1 + d1;
          m2 <= s1 - d1;
        end
      end
      if (rdy[3]) begin
        vld_pipe[3] <= vld_pipe[2];
        if (vld_pipe[2]) begin
          a_sig <= a_nx;
          b_sig <= b_nx;
          sat_a <= sa_nx;
          sat_b <= sb_nx;
        end
      end
      if (vld_pipe[3] && out_ready)
        sat_seen <= sat_seen | sat_a | sat_b;
    end
  end
endmodule
